// File: rtl/nios2_pio_in_if.sv
// Avalon-MM slave bus bundle for the nios2_pio_in input port, including its level interrupt.
interface nios2_pio_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/nios2_pio_in.sv
// Avalon-MM input PIO: synchronized level, per-bit edge capture, interrupt mask and level IRQ.
// Optional build macro NIOS2_PIO_IN_BITCLR_EN selects write-1-to-clear edge capture.
module nios2_pio_in #(
  parameter int WIDTH       = 20,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  nios2_pio_in_if.slave    bus
);

  localparam int ARM_MAX = SYNC_STAGES + 1;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain_r;
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] edge_capture_r;
  logic [WIDTH-1:0] irq_mask_r;
  logic [2:0]       arm_cnt_r;
  logic [31:0]      readdata_r;

  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] det_raw_s;
  logic [WIDTH-1:0] det_s;
  logic [WIDTH-1:0] clr_s;
  logic [31:0]      rd_mux_s;
  logic             armed_s;
  logic             rd_en_s;
  logic             wr_en_s;
  logic             unused_wd_s;

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = 32'd0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  assign unused_wd_s = ^bus.writedata;

  // Bus strobes, arm state and edge detection on the synchronized level.
  always_comb begin
    sync_s  = sync_chain_r[SYNC_STAGES-1];
    rise_s  = sync_s & ~prev_r;
    fall_s  = ~sync_s & prev_r;
    armed_s = (arm_cnt_r == 3'(ARM_MAX));
    rd_en_s = bus.chipselect & ~bus.read_n;
    wr_en_s = bus.chipselect & ~bus.write_n;
    case (EDGE_TYPE)
      32'sd0:  det_raw_s = rise_s;
      32'sd1:  det_raw_s = fall_s;
      32'sd2:  det_raw_s = rise_s | fall_s;
      default: det_raw_s = rise_s;
    endcase
    if (armed_s) begin
      det_s = det_raw_s;
    end else begin
      det_s = {WIDTH{1'b0}};
    end
  end

  // Clear vector for the edge-capture register from a write to address 3.
  always_comb begin
    if (wr_en_s && (bus.address == 2'd3)) begin
`ifdef NIOS2_PIO_IN_BITCLR_EN
      clr_s = bus.writedata[WIDTH-1:0];
`else
      clr_s = {WIDTH{1'b1}};
`endif
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
  end

  // Read mux sees pre-write register values so same-cycle read/write returns old data.
  always_comb begin
    case (bus.address)
      2'd0:    rd_mux_s = zext(sync_s);
      2'd1:    rd_mux_s = 32'd0;
      2'd2:    rd_mux_s = zext(irq_mask_r);
      2'd3:    rd_mux_s = zext(edge_capture_r);
      default: rd_mux_s = 32'd0;
    endcase
  end

  // All register state; arm counter keeps inputs held through reset from looking like edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_chain_r   <= '0;
      prev_r         <= {WIDTH{1'b0}};
      edge_capture_r <= {WIDTH{1'b0}};
      irq_mask_r     <= {WIDTH{1'b0}};
      arm_cnt_r      <= 3'd0;
      readdata_r     <= 32'd0;
    end else begin
      sync_chain_r   <= {sync_chain_r[SYNC_STAGES-2:0], in_port};
      prev_r         <= sync_s;
      edge_capture_r <= (edge_capture_r & ~clr_s) | det_s;
      if (!armed_s) begin
        arm_cnt_r <= arm_cnt_r + 3'd1;
      end else begin
        arm_cnt_r <= arm_cnt_r;
      end
      if (wr_en_s && (bus.address == 2'd2)) begin
        irq_mask_r <= bus.writedata[WIDTH-1:0];
      end else begin
        irq_mask_r <= irq_mask_r;
      end
      if (rd_en_s) begin
        readdata_r <= rd_mux_s;
      end else begin
        readdata_r <= readdata_r;
      end
    end
  end

  assign bus.readdata = readdata_r;
  assign bus.irq      = |(edge_capture_r & irq_mask_r);

endmodule

// File: tb/tb_nios2_pio_in.sv
// Self-checking bench for nios2_pio_in: rising-edge and any-edge instances against a sample-history model.
module tb_nios2_pio_in;

  localparam int W = 20;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_port;
  logic         cmp_en = 1'b0;
  int           tests = 0;
  int           fails = 0;
  logic [31:0]  r0, r2;

  nios2_pio_in_if bus0 ();
  nios2_pio_in_if bus2 ();

  nios2_pio_in #(.WIDTH(W), .EDGE_TYPE(0), .SYNC_STAGES(S)) u_dut0 (
    .clk(clk), .reset(reset), .in_port(in_port), .bus(bus0.slave)
  );
  nios2_pio_in #(.WIDTH(W), .EDGE_TYPE(2), .SYNC_STAGES(S)) u_dut2 (
    .clk(clk), .reset(reset), .in_port(in_port), .bus(bus2.slave)
  );

  always #5 clk = ~clk;

  // Model: hist[k] is in_port as sampled k+1 edges ago; since counts edges since reset release.
  logic [W-1:0] hist [0:4];
  int           since = 0;
  logic [W-1:0] m_ec0 = '0, m_ec2 = '0, m_mask = '0;
  logic [31:0]  m_rd0 = '0, m_rd2 = '0;

  function automatic logic [31:0] reg_val(input logic [1:0] a, input logic [W-1:0] lvl,
                                          input logic [W-1:0] msk, input logic [W-1:0] ec);
    case (a)
      2'd0:    return {12'd0, lvl};
      2'd2:    return {12'd0, msk};
      2'd3:    return {12'd0, ec};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [W-1:0] sv, pv, d0, d2, clr;
    logic rd, wr;
    if (reset) begin
      for (int i = 0; i < 5; i++) hist[i] <= '0;
      since  <= 0;
      m_ec0  <= '0;
      m_ec2  <= '0;
      m_mask <= '0;
      m_rd0  <= 32'd0;
      m_rd2  <= 32'd0;
    end else begin
      sv = hist[S-1];
      pv = hist[S];
      d0 = '0;
      d2 = '0;
      if (since >= S + 1) begin
        d0 = sv & ~pv;
        d2 = sv ^ pv;
      end
      rd  = bus0.chipselect && !bus0.read_n;
      wr  = bus0.chipselect && !bus0.write_n;
      clr = '0;
      if (wr && bus0.address == 2'd3) begin
`ifdef NIOS2_PIO_IN_BITCLR_EN
        clr = bus0.writedata[W-1:0];
`else
        clr = 20'hFFFFF;
`endif
      end
      if (rd) begin
        m_rd0 <= reg_val(bus0.address, sv, m_mask, m_ec0);
        m_rd2 <= reg_val(bus0.address, sv, m_mask, m_ec2);
      end
      if (wr && bus0.address == 2'd2) m_mask <= bus0.writedata[W-1:0];
      m_ec0 <= (m_ec0 & ~clr) | d0;
      m_ec2 <= (m_ec2 & ~clr) | d2;
      for (int i = 4; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= in_port;
      if (since < 16) since <= since + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_rd0",  bus0.readdata, m_rd0);
      chk("model_rd2",  bus2.readdata, m_rd2);
      chk("model_irq0", {31'd0, bus0.irq}, {31'd0, |(m_ec0 & m_mask)});
      chk("model_irq2", {31'd0, bus2.irq}, {31'd0, |(m_ec2 & m_mask)});
    end
  end

  task automatic set_bus(input logic cs, input logic rn, input logic wn,
                         input logic [1:0] a, input logic [31:0] wd);
    bus0.chipselect = cs; bus0.read_n = rn; bus0.write_n = wn; bus0.address = a; bus0.writedata = wd;
    bus2.chipselect = cs; bus2.read_n = rn; bus2.write_n = wn; bus2.address = a; bus2.writedata = wd;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] wd);
    set_bus(1'b1, 1'b1, 1'b0, a, wd);
    tick();
    set_bus(1'b0, 1'b1, 1'b1, 2'd0, 32'd0);
  endtask

  task automatic do_read(input logic [1:0] a, output logic [31:0] d0, output logic [31:0] d2);
    set_bus(1'b1, 1'b0, 1'b1, a, 32'd0);
    tick();
    d0 = bus0.readdata;
    d2 = bus2.readdata;
    set_bus(1'b0, 1'b1, 1'b1, 2'd0, 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    in_port = 20'hFFFFF;
    set_bus(1'b0, 1'b1, 1'b1, 2'd0, 32'd0);
    repeat (3) tick();
    cmp_en = 1'b1;
    chk("rst_irq0", {31'd0, bus0.irq}, 32'd0);
    chk("rst_rd0", bus0.readdata, 32'd0);
    reset = 1'b0;

    // Inputs held high through reset must not be captured.
    repeat (8) begin
      tick();
      chk("hold_irq0", {31'd0, bus0.irq}, 32'd0);
    end
    do_read(2'd3, r0, r2);
    chk("hold_ec0", r0, 32'd0);
    chk("hold_ec2", r2, 32'd0);
    do_read(2'd0, r0, r2);
    chk("level", r0, 32'h000FFFFF);

    // Falling edges: only the any-edge instance captures.
    in_port = 20'h00000;
    repeat (4) tick();
    do_read(2'd3, r0, r2);
    chk("fall_ec0", r0, 32'd0);
    chk("fall_ec2", r2, 32'h000FFFFF);
    do_write(2'd3, 32'h000FFFFF);
    do_write(2'd2, 32'h00000001);

    // Bit0 rise sampled at edge N shows at edge N+2.
    in_port = 20'h00001;
    tick();
    chk("lat_n", {31'd0, bus0.irq}, 32'd0);
    tick();
    chk("lat_n1", {31'd0, bus0.irq}, 32'd0);
    tick();
    chk("lat_n2", {31'd0, bus0.irq}, 32'd1);
    do_read(2'd3, r0, r2);
    chk("rise_ec0", r0, 32'h1);

    // Clear semantics with edge_capture = 5.
    in_port = 20'h00005;
    repeat (3) tick();
    do_read(2'd3, r0, r2);
    chk("ec5", r0, 32'h5);
    do_write(2'd3, 32'h1);
    do_read(2'd3, r0, r2);
`ifdef NIOS2_PIO_IN_BITCLR_EN
    chk("clr_ec0", r0, 32'h4);
`else
    chk("clr_ec0", r0, 32'h0);
`endif
    chk("clr_irq0", {31'd0, bus0.irq}, 32'd0);

    // Clear lands on the same edge that captures bit3: set wins.
    do_write(2'd2, 32'h8);
    in_port = 20'h0000D;
    tick();
    tick();
    do_write(2'd3, 32'h8);
    chk("setwin_irq", {31'd0, bus0.irq}, 32'd1);
    do_read(2'd3, r0, r2);
`ifdef NIOS2_PIO_IN_BITCLR_EN
    chk("setwin_ec0", r0, 32'hC);
`else
    chk("setwin_ec0", r0, 32'h8);
`endif
    chk("setwin_irq2", {31'd0, bus0.irq}, 32'd1);

    // Any-edge capture of bit7 with mask 0, then unmask.
    do_write(2'd3, 32'h000FFFFF);
    do_write(2'd2, 32'h0);
    in_port = 20'h0008D;
    repeat (4) tick();
    in_port = 20'h0000D;
    repeat (4) tick();
    in_port = 20'h0008D;
    repeat (4) tick();
    chk("any_irq_masked", {31'd0, bus2.irq}, 32'd0);
    do_read(2'd3, r0, r2);
    chk("any_ec2", r2, 32'h80);
    do_write(2'd2, 32'h80);
    chk("any_irq_unmask", {31'd0, bus2.irq}, 32'd1);

    // One-cycle reset while irq is high.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_irq0", {31'd0, bus0.irq}, 32'd0);
    chk("mid_rst_irq2", {31'd0, bus2.irq}, 32'd0);
    chk("mid_rst_rd", bus2.readdata, 32'd0);
    do_read(2'd1, r0, r2);
    chk("rsvd_rd", r0, 32'd0);
    do_read(2'd2, r0, r2);
    chk("mask_rst", r0, 32'd0);

    // Same-cycle read and write of the mask returns the old value.
    set_bus(1'b1, 1'b0, 1'b0, 2'd2, 32'h00000123);
    tick();
    r0 = bus0.readdata;
    set_bus(1'b0, 1'b1, 1'b1, 2'd0, 32'd0);
    chk("rw_old", r0, 32'd0);
    do_read(2'd2, r0, r2);
    chk("rw_new", r0, 32'h123);
    do_write(2'd1, 32'hFFFFFFFF);
    do_read(2'd1, r0, r2);
    chk("rsvd_wr", r0, 32'd0);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
